// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
//   Shared definitions for the 8-bit PRBS (x^8+x^6+x^5+x+1 Galois LFSR)
//   generator and checker.
//   PRBS8_W     : PRBS word width
//   chk_state_t : checker synchronisation state
//   prbs8_nxt() : one generator step (next word from current word)
// ---------------------------------------------------------------------------
package prbs_pkg;

  localparam int unsigned PRBS8_W = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } chk_state_t;

  // One Galois LFSR step; maps nonzero words to nonzero words.
  function automatic logic [PRBS8_W-1:0] prbs8_nxt(input logic [PRBS8_W-1:0] c);
    logic [PRBS8_W-1:0] n;
    n[7] = c[6];
    n[6] = c[5] ^ c[7];
    n[5] = c[4] ^ c[7];
    n[4] = c[3];
    n[3] = c[2];
    n[2] = c[1];
    n[1] = c[0] ^ c[7];
    n[0] = c[7];
    return n;
  endfunction

endpackage

// File: rtl/prbs8_popcnt.sv
// ---------------------------------------------------------------------------
// prbs8_popcnt
//   Combinational population count of an 8-bit word.
//   i_data  : word to count
//   o_cnt_c : number of set bits (0..8)
// ---------------------------------------------------------------------------
module prbs8_popcnt
  import prbs_pkg::*;
(
  input  logic [PRBS8_W-1:0] i_data,
  output logic [3:0]         o_cnt_c
);

  always_comb begin
    o_cnt_c = '0;
    for (int unsigned i = 0; i < PRBS8_W; i++) begin
      o_cnt_c = o_cnt_c + 4'(i_data[i]);
    end
  end

endmodule

// File: rtl/prbs8_checker.sv
// ---------------------------------------------------------------------------
// prbs8_checker
//   Receive-side checker for the 8-bit PRBS stream. Self-synchronises
//   (HUNT -> VERIFY -> LOCK), then flywheels its own prediction and counts
//   mismatching words while locked.
//   Optional feature macro: PRBS_CHK_BITCNT_EN adds bit_err_cnt, the
//   saturating count of bit errors seen on words received in LOCK.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear of the error counters and err_sat
//   din_vld, din : received word and its qualifier
//   locked       : checker is in LOCK
//   err_pulse    : previous valid word mismatched while in LOCK
//   err_cnt      : saturating count of mismatched words in LOCK
//   err_sat      : err_cnt has reached all-ones (sticky until clr/reset)
//   bit_err_cnt  : (PRBS_CHK_BITCNT_EN only) saturating bit-error count
// ---------------------------------------------------------------------------
module prbs8_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               din_vld,
  input  logic [PRBS8_W-1:0] din,
  output logic               locked,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               err_sat
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [CNT_W-1:0]   bit_err_cnt
`endif
);

  localparam int unsigned RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX) + 1;

  localparam logic [RUN_W-1:0] GOOD_LAST  = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] BAD_LAST   = RUN_W'(LOSS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_W'(1);

  chk_state_t         r_state;
  logic [PRBS8_W-1:0] r_pred;
  logic [RUN_W-1:0]   r_good;
  logic [RUN_W-1:0]   r_bad;
  logic               r_locked;
  logic               r_err_pulse;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_err_sat;

  logic [PRBS8_W-1:0] w_nxt_din;
  logic [PRBS8_W-1:0] w_nxt_pred;
  logic               w_match;
  logic               w_din_zero;
  logic               w_lock_word;
  logic               w_lock_err;

  assign w_nxt_din   = prbs8_nxt(din);
  assign w_nxt_pred  = prbs8_nxt(r_pred);
  assign w_match     = (din == r_pred);
  assign w_din_zero  = (din == '0);
  assign w_lock_word = din_vld && (r_state == LOCK);
  assign w_lock_err  = w_lock_word && !w_match;

  // Synchronisation FSM with registered lock/error-pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_pred      <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (din_vld) begin
        unique case (r_state)
          HUNT: begin
            // All-zero is the LFSR lock-up word; never seed from it.
            if (!w_din_zero) begin
              r_pred  <= w_nxt_din;
              r_good  <= '0;
              r_state <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_pred <= w_nxt_din;
              r_good <= r_good + RUN_W'(1);
              if (r_good == GOOD_LAST) begin
                r_state  <= LOCK;
                r_locked <= 1'b1;
                r_bad    <= '0;
              end
            end else begin
              r_good <= '0;
              if (!w_din_zero) begin
                r_pred <= w_nxt_din;
              end else begin
                r_state <= HUNT;
              end
            end
          end
          LOCK: begin
            // Flywheel: prediction advances from itself, never from din.
            r_pred <= w_nxt_pred;
            if (w_match) begin
              r_bad <= '0;
            end else begin
              r_err_pulse <= 1'b1;
              r_bad       <= r_bad + RUN_W'(1);
              if (r_bad == BAD_LAST) begin
                r_state  <= HUNT;
                r_locked <= 1'b0;
              end
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating word-error counter; clr has priority over a coincident error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_err_sat <= 1'b0;
    end else if (clr) begin
      r_err_cnt <= '0;
      r_err_sat <= 1'b0;
    end else if (w_lock_err) begin
      if (r_err_cnt == CNT_MAX) begin
        r_err_sat <= 1'b1;
      end else begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (r_err_cnt == CNT_MAX_M1) begin
          r_err_sat <= 1'b1;
        end
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign err_sat   = r_err_sat;

`ifdef PRBS_CHK_BITCNT_EN
  logic [PRBS8_W-1:0] w_diff;
  logic [3:0]         w_pop_c;
  logic [CNT_W:0]     w_bit_sum;
  logic [CNT_W-1:0]   r_bit_err_cnt;

  assign w_diff = din ^ r_pred;

  prbs8_popcnt u_popcnt (
    .i_data  (w_diff),
    .o_cnt_c (w_pop_c)
  );

  // Extra carry bit detects overflow so the count clamps at all-ones.
  assign w_bit_sum = {1'b0, r_bit_err_cnt} + (CNT_W + 1)'(w_pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_err_cnt <= '0;
    end else if (clr) begin
      r_bit_err_cnt <= '0;
    end else if (w_lock_word) begin
      r_bit_err_cnt <= w_bit_sum[CNT_W] ? CNT_MAX : w_bit_sum[CNT_W-1:0];
    end
  end

  assign bit_err_cnt = r_bit_err_cnt;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs8_checker
//   Self-checking bench for prbs8_checker: constant vector table, hand
//   sequences for gaps / saturation / asynchronous reset, and a randomized
//   run against a behavioural model of the checker.
// ---------------------------------------------------------------------------
module tb_prbs8_checker;

  localparam int unsigned M_LOCK = 4;
  localparam int unsigned M_LOSS = 3;
  localparam int unsigned M_MAX  = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, din_vld;
  logic [7:0]  din;
  logic        locked, err_pulse, err_sat;
  logic [15:0] err_cnt;

  logic        d2_clr, d2_vld;
  logic [7:0]  d2_din;
  logic        locked2, err_pulse2, err_sat2;
  logic [3:0]  err_cnt2;

`ifdef PRBS_CHK_BITCNT_EN
  logic [15:0] bit_err_cnt;
  logic [3:0]  bit_err_cnt2;
`endif

  always #5 clk = ~clk;

  prbs8_checker u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .din_vld    (din_vld),
    .din        (din),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .err_sat    (err_sat)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_err_cnt(bit_err_cnt)
`endif
  );

  prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(32), .CNT_W(4)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (d2_clr),
    .din_vld    (d2_vld),
    .din        (d2_din),
    .locked     (locked2),
    .err_pulse  (err_pulse2),
    .err_cnt    (err_cnt2),
    .err_sat    (err_sat2)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_err_cnt(bit_err_cnt2)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: sync mode 0=hunting 1=verifying 2=locked.
  int         m_mode;
  logic [7:0] m_pred;
  int         m_good, m_bad, m_err, m_bit;
  bit         m_sat, m_pulse;

  // Multiply by x modulo the feedback polynomial 0x163.
  function automatic logic [7:0] ref_nxt(input logic [7:0] c);
    logic [8:0] t;
    t = {c, 1'b0};
    if (t[8]) t = t ^ 9'h163;
    return t[7:0];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pred = '0; m_good = 0; m_bad = 0;
    m_err = 0; m_bit = 0; m_sat = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    bit lock_word, lock_err;
    int bits;
    lock_word = v && (m_mode == 2);
    lock_err  = lock_word && (d != m_pred);
    bits      = $countones(d ^ m_pred);
    m_pulse   = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin m_pred = ref_nxt(d); m_good = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == m_pred) begin
          m_pred = ref_nxt(d);
          m_good++;
          if (m_good == M_LOCK) begin m_mode = 2; m_bad = 0; end
        end else begin
          m_good = 0;
          if (d != 0) m_pred = ref_nxt(d);
          else        m_mode = 0;
        end
      end else begin
        m_pred = ref_nxt(m_pred);
        if (!lock_err) m_bad = 0;
        else begin
          m_pulse = 1;
          m_bad++;
          if (m_bad == M_LOSS) m_mode = 0;
        end
      end
    end
    if (c) begin
      m_err = 0; m_sat = 0; m_bit = 0;
    end else begin
      if (lock_err) begin
        m_err = (m_err + 1 > M_MAX) ? M_MAX : m_err + 1;
        if (m_err == M_MAX) m_sat = 1;
      end
      if (lock_word) m_bit = (m_bit + bits > M_MAX) ? M_MAX : m_bit + bits;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("locked",    32'(locked),    32'(m_mode == 2));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_cnt",   32'(err_cnt),   32'(m_err));
    chk("err_sat",   32'(err_sat),   32'(m_sat));
`ifdef PRBS_CHK_BITCNT_EN
    chk("bit_err_cnt", 32'(bit_err_cnt), 32'(m_bit));
`endif
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    din_vld = v; din = d; clr = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
  endtask

  task automatic step2(input logic v, input logic [7:0] d, input logic c);
    d2_vld = v; d2_din = d; d2_clr = c;
    @(posedge clk);
    model_step(din_vld, din, clr);
    #1;
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       clr;
    logic       e_locked;
    logic       e_pulse;
    int         e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic c,
                     input logic el, input logic ep, input int ec);
    vec_t r;
    r.vld = v; r.din = d; r.clr = c; r.e_locked = el; r.e_pulse = ep; r.e_cnt = ec;
    tbl.push_back(r);
  endtask

  initial begin
    int e0;
    int b0;
    rst_n = 1'b0; clr = 1'b0; din_vld = 1'b0; din = '0;
    d2_clr = 1'b0; d2_vld = 1'b0; d2_din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_pulse",  32'(err_pulse), 32'd0);
    chk("rst_cnt",    32'(err_cnt), 32'd0);
    chk("rst_sat",    32'(err_sat), 32'd0);
    rst_n = 1'b1;

    // Acquisition, single error, loss of lock, relock, clr with error.
    add(1, 8'h01, 0, 0, 0, 0);  add(1, 8'h02, 0, 0, 0, 0);
    add(1, 8'h04, 0, 0, 0, 0);  add(1, 8'h08, 0, 0, 0, 0);
    add(1, 8'h10, 0, 1, 0, 0);  add(1, 8'h20, 0, 1, 0, 0);
    add(1, 8'h40, 0, 1, 0, 0);  add(1, 8'h80, 0, 1, 0, 0);
    add(1, 8'h00, 0, 1, 1, 1);  add(1, 8'hC6, 0, 1, 0, 1);
    add(1, 8'hEF, 0, 1, 0, 1);  add(1, 8'h00, 0, 1, 1, 2);
    add(1, 8'h00, 0, 1, 1, 3);  add(1, 8'h00, 0, 0, 1, 4);
    add(1, 8'h00, 0, 0, 0, 4);  add(1, 8'h05, 0, 0, 0, 4);
    add(1, 8'h0A, 0, 0, 0, 4);  add(1, 8'h14, 0, 0, 0, 4);
    add(1, 8'h28, 0, 0, 0, 4);  add(1, 8'h50, 0, 1, 0, 4);
    add(1, 8'hA0, 0, 1, 0, 4);  add(0, 8'hFF, 0, 1, 0, 4);
    add(1, 8'h23, 0, 1, 0, 4);  add(1, 8'h00, 1, 1, 1, 0);
    add(0, 8'h00, 0, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].vld, tbl[i].din, tbl[i].clr);
      chk($sformatf("tbl%0d_locked", i), 32'(locked),    32'(tbl[i].e_locked));
      chk($sformatf("tbl%0d_pulse", i),  32'(err_pulse), 32'(tbl[i].e_pulse));
      chk($sformatf("tbl%0d_cnt", i),    32'(err_cnt),   32'(tbl[i].e_cnt));
    end

    // Gapped but correct stream while locked: no errors, lock holds.
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) step(1'b1, m_pred, 1'b0);
      else            step(1'b0, 8'($urandom), 1'b0);
      chk("gap_locked", 32'(locked), 32'd1);
      chk("gap_pulse",  32'(err_pulse), 32'd0);
      chk("gap_cnt",    32'(err_cnt), 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic       v, c;
      logic [7:0] d;
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 49) == 0);
      if (m_mode != 0 && $urandom_range(0, 19) < 17) d = m_pred;
      else if ($urandom_range(0, 9) == 0)            d = 8'h00;
      else                                           d = 8'($urandom);
      step(v, d, c);
      chk_model();
    end

    // Reacquire lock (bounded), then asynchronous reset between edges.
    for (int i = 0; i < 40 && m_mode != 2; i++) begin
      if (m_mode == 0) step(1'b1, 8'h01, 1'b0);
      else             step(1'b1, m_pred, 1'b0);
    end
    chk("relock_locked", 32'(locked), 32'd1);
    e0 = m_err;
    b0 = m_bit;
    step(1'b1, m_pred ^ 8'h1F, 1'b0);
    chk("one_err_cnt", 32'(err_cnt), 32'(e0 + 1 > M_MAX ? M_MAX : e0 + 1));
`ifdef PRBS_CHK_BITCNT_EN
    chk("bit_err_plus5", 32'(bit_err_cnt), 32'(b0 + 5 > M_MAX ? M_MAX : b0 + 5));
`else
    b0 = b0 + 0;
`endif
    step(1'b1, m_pred, 1'b0);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_pulse",  32'(err_pulse), 32'd0);
    chk("arst_cnt",    32'(err_cnt), 32'd0);
    chk("arst_sat",    32'(err_sat), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    din_vld = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    chk_model();

    // Narrow counter: saturation, then clr together with an error.
    foreach (tbl[i]) if (i < 5) step2(1'b1, tbl[i].din, 1'b0);
    chk("d2_locked", 32'(locked2), 32'd1);
    for (int i = 1; i <= 20; i++) begin
      step2(1'b1, 8'h00, 1'b0);
      if (i == 14) begin
        chk("d2_cnt14", 32'(err_cnt2), 32'd14);
        chk("d2_sat14", 32'(err_sat2), 32'd0);
      end
    end
    chk("d2_cnt_sat",  32'(err_cnt2), 32'hF);
    chk("d2_sat",      32'(err_sat2), 32'd1);
    chk("d2_still_lk", 32'(locked2), 32'd1);
    step2(1'b1, 8'h00, 1'b1);
    chk("d2_clr_cnt",   32'(err_cnt2), 32'd0);
    chk("d2_clr_sat",   32'(err_sat2), 32'd0);
    chk("d2_clr_pulse", 32'(err_pulse2), 32'd1);
    step2(1'b0, 8'h00, 1'b0);
    chk("d2_idle_pulse", 32'(err_pulse2), 32'd0);
    chk("d1_idle", 32'(err_cnt), 32'(m_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
